mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle controller that sequences an iterative shift-add 64-bit multiply (LEGv8 MUL, low N bits of Xn*Xm) alongside the execute stage.
- Accepts a start request from decode/execute control and stalls the pipeline while busy.
- Delivers the product with a one-cycle done pulse.
- Supports pipeline flush, which kills an in-flight operation.

Parameters:
- N, 64, operand and product width.
- EARLY_EXIT, 1, when 1 the sequence ends once the remaining multiplier bits are all zero.
- CW, $clog2(N), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_E  input  1  MUL instruction present in execute; level, held while stalled.
- flush_E  input  1  kill current operation; priority over start_E.
- multiplicand_E  input  N  operand A (readData1_E).
- multiplier_E  input  N  operand B (readData2_E).
- stall_E  output  1  freeze PC and pipeline registers upstream of execute.
- busy_E  output  1  state is RUN.
- done_E  output  1  one-cycle pulse; product_E valid.
- product_E  output  N  registered low N bits of A*B.

Behaviour:
- Reset (reset low, asynchronous) puts the block in the following state:
  - state = IDLE.
  - acc, A_reg, B_reg, count and product_E = 0.
  - done_E = 0, busy_E = 0, stall_E = 0.
  - Reset asserted mid-RUN aborts immediately; no done_E follows.
- State type: enum IDLE, RUN, DONE.
- IDLE:
  - If start_E=1 and flush_E=0: latch A_reg=multiplicand_E, B_reg=multiplier_E, acc=0, count=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, per cycle:
  - If B_reg[0], acc <= acc + A_reg, truncated mod 2^N.
  - A_reg <= A_reg<<1, B_reg <= B_reg>>1, count <= count+1.
  - Go to DONE when count==N-1, or when EARLY_EXIT && (B_reg>>1)==0.
  - On the DONE transition, product_E <= acc plus the final addend, i.e. the value acc takes that edge.
- DONE:
  - done_E=1 for exactly this cycle.
  - Always returns to IDLE.
  - start_E is ignored here: it is still the retiring instruction.
- stall_E is combinational: (IDLE && start_E && !flush_E) || RUN. It is 0 in DONE so the MUL retires that cycle.
- busy_E = (state==RUN).
- flush_E=1 in any state:
  - Next state is IDLE; done_E is suppressed.
  - product_E keeps its previous value.
  - stall_E is forced to 0 that cycle.
- Latency, counted in cycles after the start edge:
  - RUN cycles = max(1, msb_index(B)+1) with EARLY_EXIT, else N.
  - done_E is asserted the cycle after the last RUN cycle.
  - B=0 gives 1 RUN cycle, then DONE.
- Arithmetic:
  - Unsigned shift-add. The low N bits are identical for signed operands, so there is no sign handling.
  - Overflow is discarded silently.
- product_E holds its value until the next completed operation.
- Back-to-back MULs: the second start_E is seen in IDLE the cycle after DONE, so there is no bubble beyond DONE.

Decomposition:
- Package mul_pkg contains:
  - typedef enum logic [1:0] mul_state_t {IDLE, RUN, DONE}.
  - localparam MUL_N_DEFAULT = 64.
- Sub-module mul_datapath (N) contains:
  - acc/A_reg/B_reg registers with load, step and clear controls.
  - The existing adder #(N) for accumulation.
  - A flag output b_next_zero.
- FSM, counter and stall logic live in mul_sequencer.

Test Plan:
- A=3, B=5, EARLY_EXIT=1, start_E held:
  - 3 RUN cycles, then done_E in cycle 4 with product_E=15.
  - stall_E=1 from the start cycle through the last RUN cycle.
- A=0x1234, B=0:
  - 1 RUN cycle, then done_E with product_E=0.
- A=B=64'hFFFF_FFFF_FFFF_FFFF:
  - 64 RUN cycles, then done_E with product_E=1.
  - With EARLY_EXIT=0, A=2, B=1 also takes 64 RUN cycles, product_E=2.
- Start A=7, B=9 with product_E previously 15; assert flush_E in RUN cycle 2:
  - Next state IDLE, no done_E, product_E stays 15, stall_E drops the same cycle.
- Drive reset low mid-RUN:
  - All outputs 0 asynchronously, state IDLE.
  - After release, a new start A=6, B=7 gives product_E=42.
- Two back-to-back MULs (3×5, then 4×4):
  - done_E pulses give 15 then 16.
  - start_E during DONE does not restart the first operation.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and defaults for the iterative multiply sequencer.
package mul_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

   localparam int unsigned MUL_N_DEFAULT = 64;

endpackage

// File: rtl/adder.sv
// Plain N-bit adder; carry out is dropped so sums wrap mod 2^N.
module adder #(
   parameter int unsigned N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/mul_datapath.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier registers.
module mul_datapath
   import mul_pkg::*;
#(
   parameter int unsigned N = MUL_N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         step,
   input  logic [N-1:0] multiplicand,
   input  logic [N-1:0] multiplier,
   output logic [N-1:0] acc_next,
   output logic         b_next_zero
);

   logic [N-1:0] acc_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic [N-1:0] addend;
   logic [N-1:0] acc_sum;

   // Add the shifted multiplicand only when the current multiplier bit is set.
   always_comb begin
      addend = b_q[0] ? a_q : '0;
   end

   adder #(
      .N (N)
   ) u_adder (
      .a   (acc_q),
      .b   (addend),
      .sum (acc_sum)
   );

   // Value the accumulator takes on a step edge; the sequencer captures it as the product.
   always_comb begin
      acc_next    = acc_sum;
      b_next_zero = ((b_q >> 1) == '0);
   end

   // Operand and accumulator registers: clear beats load beats step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (clear) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (load) begin
         acc_q <= '0;
         a_q   <= multiplicand;
         b_q   <= multiplier;
      end else if (step) begin
         acc_q <= acc_sum;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller: stalls the pipeline while a shift-add multiply runs,
// then pulses done_E for one cycle with the registered low N bits of the product.
module mul_sequencer
   import mul_pkg::*;
#(
   parameter int unsigned N          = MUL_N_DEFAULT,
   parameter int unsigned EARLY_EXIT = 1,
   parameter int unsigned CW         = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_E,
   input  logic         flush_E,
   input  logic [N-1:0] multiplicand_E,
   input  logic [N-1:0] multiplier_E,
   output logic         stall_E,
   output logic         busy_E,
   output logic         done_E,
   output logic [N-1:0] product_E
);

   mul_state_t      state_q;
   mul_state_t      state_d;
   logic [CW-1:0]   count_q;
   logic            dp_load;
   logic            dp_step;
   logic            dp_clear;
   logic [N-1:0]    acc_next;
   logic            b_next_zero;
   logic            last_step;

   mul_datapath #(
      .N (N)
   ) u_datapath (
      .clk          (clk),
      .reset        (reset),
      .clear        (dp_clear),
      .load         (dp_load),
      .step         (dp_step),
      .multiplicand (multiplicand_E),
      .multiplier   (multiplier_E),
      .acc_next     (acc_next),
      .b_next_zero  (b_next_zero)
   );

   // Last RUN cycle: all N bits consumed, or no set multiplier bits remain.
   always_comb begin
      last_step = (count_q == CW'(N - 1)) || ((EARLY_EXIT != 0) && b_next_zero);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush kills whatever is in flight.
   always_comb begin
      state_d = state_q;
      if (flush_E) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_E) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs and datapath controls; DONE does not stall so the MUL retires there.
   always_comb begin
      dp_load  = (state_q == IDLE) && start_E && !flush_E;
      dp_step  = (state_q == RUN) && !flush_E;
      dp_clear = flush_E;
      stall_E  = dp_load || dp_step;
      busy_E   = (state_q == RUN);
      done_E   = (state_q == DONE) && !flush_E;
   end

   // Iteration counter and product capture on the final step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= '0;
         product_E <= '0;
      end else if (dp_load) begin
         count_q <= '0;
      end else if (dp_step) begin
         count_q <= count_q + CW'(1);
         if (last_step) begin
            product_E <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench: two sequencers (early exit on/off) against a latency/product model.
module tb_mul_sequencer;

   localparam int unsigned N = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_s [2];
   logic         flush_s [2];
   logic [N-1:0] a_s     [2];
   logic [N-1:0] b_s     [2];
   logic         stall_s [2];
   logic         busy_s  [2];
   logic         done_s  [2];
   logic [N-1:0] prod_s  [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_sequencer #(
      .N          (N),
      .EARLY_EXIT (1)
   ) dut_early (
      .clk            (clk),
      .reset          (rst_n),
      .start_E        (start_s[0]),
      .flush_E        (flush_s[0]),
      .multiplicand_E (a_s[0]),
      .multiplier_E   (b_s[0]),
      .stall_E        (stall_s[0]),
      .busy_E         (busy_s[0]),
      .done_E         (done_s[0]),
      .product_E      (prod_s[0])
   );

   mul_sequencer #(
      .N          (N),
      .EARLY_EXIT (0)
   ) dut_full (
      .clk            (clk),
      .reset          (rst_n),
      .start_E        (start_s[1]),
      .flush_E        (flush_s[1]),
      .multiplicand_E (a_s[1]),
      .multiplier_E   (b_s[1]),
      .stall_E        (stall_s[1]),
      .busy_E         (busy_s[1]),
      .done_E         (done_s[1]),
      .product_E      (prod_s[1])
   );

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase 0 idle, 1 running (rem cycles left), 2 done cycle.
   int           ph    [2];
   int           rem   [2];
   logic [N-1:0] pend  [2];
   logic [N-1:0] mprod [2];

   // Number of RUN cycles for multiplier b.
   function automatic int lat(input logic [N-1:0] b, input bit early);
      int r;
      r = 1;
      if (!early) return int'(N);
      for (int i = 0; i < int'(N); i++) if (b[i]) r = i + 1;
      return r;
   endfunction

   // Advance the model on each clock edge; reset is asynchronous.
   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            ph[d]    = 0;
            rem[d]   = 0;
            mprod[d] = '0;
         end else if (flush_s[d]) begin
            ph[d] = 0;
         end else begin
            case (ph[d])
               0: if (start_s[d]) begin
                  ph[d]   = 1;
                  rem[d]  = lat(b_s[d], d == 0);
                  pend[d] = a_s[d] * b_s[d];
               end
               1: begin
                  rem[d]--;
                  if (rem[d] == 0) begin
                     ph[d]    = 2;
                     mprod[d] = pend[d];
                  end
               end
               default: ph[d] = 0;
            endcase
         end
      end
   end

   // Compare every output of both DUTs against the model on each falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("stall[%0d]", d), N'(stall_s[d]),
                  N'(!flush_s[d] && ((ph[d] == 0 && start_s[d]) || ph[d] == 1)));
            check($sformatf("busy[%0d]", d), N'(busy_s[d]), N'(ph[d] == 1));
            check($sformatf("done[%0d]", d), N'(done_s[d]), N'(ph[d] == 2 && !flush_s[d]));
            check($sformatf("product[%0d]", d), prod_s[d], mprod[d]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input int d, input logic [N-1:0] a, input logic [N-1:0] b);
      start_s[d] = 1'b1;
      a_s[d]     = a;
      b_s[d]     = b;
   endtask

   // Returns edges from the drive point until done_E is seen, or -1 on timeout.
   task automatic wait_done(input int d, output int k, output logic [N-1:0] p);
      bit seen;
      seen = 1'b0;
      k    = -1;
      p    = '0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done_s[d]) begin
            seen = 1'b1;
            k    = i;
            p    = prod_s[d];
         end
      end
   endtask

   task automatic go_idle(input int d);
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
   endtask

   task automatic run_directed(input int d, input logic [N-1:0] a, input logic [N-1:0] b,
                               input int exp_k, input logic [N-1:0] exp_p, input string tag);
      int           k;
      logic [N-1:0] p;
      drive(d, a, b);
      wait_done(d, k, p);
      check({tag, " latency"}, N'(k), N'(exp_k));
      check({tag, " product"}, p, exp_p);
   endtask

   initial begin
      int           k;
      logic [N-1:0] p;
      logic [N-1:0] bb;
      bit           held [2];

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         flush_s[d] = 1'b0;
         a_s[d]     = '0;
         b_s[d]     = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("reset stall", N'(stall_s[0]), '0);
      check("reset busy", N'(busy_s[0]), '0);
      check("reset done", N'(done_s[0]), '0);
      check("reset product", prod_s[0], '0);
      @(posedge clk);
      #1;

      run_directed(0, 64'd3, 64'd5, 4, 64'd15, "3x5");
      go_idle(0);
      run_directed(0, 64'h1234, 64'd0, 2, 64'd0, "B=0");
      go_idle(0);
      run_directed(0, '1, '1, 65, 64'd1, "ones x ones");
      go_idle(0);
      run_directed(0, 64'd3, 64'd5, 4, 64'd15, "3x5 again");
      go_idle(0);

      // Flush during RUN cycle 2 of 7x9.
      drive(0, 64'd7, 64'd9);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush_s[0] = 1'b1;
      #1;
      check("flush stall drop", N'(stall_s[0]), '0);
      check("flush no done", N'(done_s[0]), '0);
      @(posedge clk);
      #1;
      flush_s[0] = 1'b0;
      start_s[0] = 1'b0;
      check("flush to idle", N'(busy_s[0]), '0);
      repeat (6) @(posedge clk);
      #1;
      check("flush keeps product", prod_s[0], 64'd15);

      // Back-to-back: second start is presented during the DONE cycle.
      run_directed(0, 64'd3, 64'd5, 4, 64'd15, "b2b first");
      run_directed(0, 64'd4, 64'd4, 5, 64'd16, "b2b second");
      go_idle(0);

      // Asynchronous reset mid-RUN.
      drive(0, 64'd7, 64'd9);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n      = 1'b0;
      start_s[0] = 1'b0;
      #1;
      check("async reset stall", N'(stall_s[0]), '0);
      check("async reset busy", N'(busy_s[0]), '0);
      check("async reset done", N'(done_s[0]), '0);
      check("async reset product", prod_s[0], '0);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_directed(0, 64'd6, 64'd7, 4, 64'd42, "6x7 after reset");
      go_idle(0);

      // No early exit: full N RUN cycles regardless of B.
      run_directed(1, 64'd2, 64'd1, 65, 64'd2, "full 2x1");
      go_idle(1);
      run_directed(1, '1, '1, 65, 64'd1, "full ones");
      go_idle(1);

      // Randomized phase: hold the instruction while the pipeline is stalled.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) held[d] = stall_s[d];
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (!held[d]) begin
               start_s[d] = ($urandom_range(0, 2) != 0);
               a_s[d]     = {$urandom, $urandom};
               bb         = {$urandom, $urandom};
               case ($urandom_range(0, 7))
                  0:       bb = '0;
                  1:       bb = '1;
                  default: bb = bb >> $urandom_range(0, 63);
               endcase
               b_s[d] = bb;
            end
            flush_s[d] = ($urandom_range(0, 29) == 0);
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         flush_s[d] = 1'b0;
      end
      repeat (70) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
